// File: rtl/fp_accum_master.sv
// Packet accumulator that sequences a multi-cycle fpadd unit over a valid/ready
// operand stream and returns the packet sum and element count.
module fp_accum_master #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [31:0]      acc_data,
  output logic [CNT_W-1:0] count,
  output logic             add_start,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_sum,
  input  logic             add_done,
  output logic             err_timeout
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_EMIT   = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [31:0]        acc_r, acc_s;
  logic [31:0]        elem_r, elem_s;
  logic               last_r, last_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic [WAIT_W-1:0]  wait_cnt_r, wait_cnt_s;
  logic               err_r, err_s;
  logic               in_ready_r, start_r, valid_r;
  logic               in_hs_s, acc_hs_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  assign in_hs_s  = in_valid & in_ready_r;
  assign acc_hs_s = valid_r & acc_ready;

  // Next-state and datapath update decode
  always_comb begin
    state_s    = state_r;
    acc_s      = acc_r;
    elem_s     = elem_r;
    last_s     = last_r;
    count_s    = count_r;
    wait_cnt_s = wait_cnt_r;
    err_s      = err_r;
    case (state_r)
      ST_IDLE: begin
        if (in_hs_s) begin
          acc_s   = in_data;
          count_s = CNT_W'(1);
          state_s = in_last ? ST_EMIT : ST_ACCEPT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCEPT: begin
        if (in_hs_s) begin
          elem_s  = in_data;
          last_s  = in_last;
          count_s = sat_inc(count_r);
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_ACCEPT;
        end
      end
      ST_ISSUE: begin
        wait_cnt_s = {WAIT_W{1'b0}};
        state_s    = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the final allowed cycle still wins over the abort
        if (add_done) begin
          acc_s   = add_sum;
          state_s = last_r ? ST_EMIT : ST_ACCEPT;
        end else if (wait_cnt_r == WAIT_LAST) begin
          err_s   = 1'b1;
          state_s = last_r ? ST_EMIT : ST_DRAIN;
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (in_hs_s) begin
          count_s = sat_inc(count_r);
          state_s = in_last ? ST_EMIT : ST_DRAIN;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_EMIT: begin
        if (acc_hs_s) begin
          count_s = {CNT_W{1'b0}};
          state_s = ST_IDLE;
        end else begin
          state_s = ST_EMIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered output flops; outputs follow the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      acc_r      <= 32'd0;
      elem_r     <= 32'd0;
      last_r     <= 1'b0;
      count_r    <= {CNT_W{1'b0}};
      wait_cnt_r <= {WAIT_W{1'b0}};
      err_r      <= 1'b0;
      in_ready_r <= 1'b0;
      start_r    <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      acc_r      <= acc_s;
      elem_r     <= elem_s;
      last_r     <= last_s;
      count_r    <= count_s;
      wait_cnt_r <= wait_cnt_s;
      err_r      <= err_s;
      in_ready_r <= (state_s == ST_IDLE) || (state_s == ST_ACCEPT) || (state_s == ST_DRAIN);
      start_r    <= (state_s == ST_ISSUE);
      valid_r    <= (state_s == ST_EMIT);
    end
  end

  // acc_r only moves on an accepted done, so add_a is stable across WAIT
  assign in_ready    = in_ready_r;
  assign add_start   = start_r;
  assign add_a       = acc_r;
  assign add_b       = elem_r;
  assign acc_valid   = valid_r;
  assign acc_data    = acc_r;
  assign count       = count_r;
  assign err_timeout = err_r;

endmodule

// File: tb/tb_fp_accum_master.sv
// Directed bench for fp_accum_master with a behavioural fpadd stand-in whose
// latency can be set per scenario or stalled forever.
module tb_fp_accum_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        in_last = 1'b0;
  logic        acc_valid;
  logic        acc_ready = 1'b0;
  logic [31:0] acc_data;
  logic [7:0]  count;
  logic        add_start;
  logic [31:0] add_a, add_b;
  logic [31:0] add_sum;
  logic        add_done;
  logic        err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  fp_accum_master #(.CNT_W(8), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data), .count(count),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_done(add_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Hand-computed single-precision sums for the operand pairs used here
  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;
      64'h40400000_3F000000: return 32'h40600000;
      default:               return 32'hBAD0BAD0;
    endcase
  endfunction

  // fpadd stand-in: done drops on start, rises lat_m edges later unless hung
  logic        done_m = 1'b0;
  logic        busy_m = 1'b0;
  logic [31:0] sum_m = 32'd0;
  logic [31:0] opa_m = 32'd0;
  logic [31:0] opb_m = 32'd0;
  int          lat_cnt_m = 0;
  int          lat_m = 3;
  bit          hang_m = 1'b0;

  assign add_done = done_m;
  assign add_sum  = sum_m;

  always @(posedge clk) begin
    if (add_start) begin
      done_m    <= 1'b0;
      busy_m    <= 1'b1;
      lat_cnt_m <= 1;
      opa_m     <= add_a;
      opb_m     <= add_b;
    end else if (busy_m && !hang_m) begin
      if (lat_cnt_m >= lat_m) begin
        done_m <= 1'b1;
        sum_m  <= fp_ref(opa_m, opb_m);
        busy_m <= 1'b0;
      end else begin
        lat_cnt_m <= lat_cnt_m + 1;
      end
    end
  end

  // Issue log and back-to-back start detector
  logic [31:0] issue_a[$];
  logic [31:0] issue_b[$];
  int          start_cnt = 0;
  int          dbl_start = 0;
  logic        prev_start = 1'b0;

  always @(posedge clk) begin
    prev_start <= add_start;
    if (add_start) begin
      issue_a.push_back(add_a);
      issue_b.push_back(add_b);
      start_cnt <= start_cnt + 1;
      if (prev_start) dbl_start <= dbl_start + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_elem(input logic [31:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!acc_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("acc_valid_wait", 32'(acc_valid), 32'd1);
  endtask

  task automatic get_sum(input string tag, input logic [31:0] exp_d, input logic [7:0] exp_c);
    wait_valid();
    check({tag, "_data"}, acc_data, exp_d);
    check({tag, "_count"}, 32'(count), 32'(exp_c));
    acc_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_acc_valid"}, 32'(acc_valid), 32'd0);
    check({tag, "_acc_data"}, acc_data, 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_add_start"}, 32'(add_start), 32'd0);
    check({tag, "_add_a"}, add_a, 32'd0);
    check({tag, "_add_b"}, add_b, 32'd0);
    check({tag, "_err"}, 32'(err_timeout), 32'd0);
  endtask

  task automatic send_three();
    send_elem(32'h3F800000, 1'b0);
    send_elem(32'h40000000, 1'b0);
    send_elem(32'h3F000000, 1'b1);
  endtask

  initial begin
    int s0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    check("rst_idle_ready", 32'(in_ready), 32'd1);

    // Single element: no add
    s0 = start_cnt;
    send_elem(32'h3F800000, 1'b1);
    get_sum("single", 32'h3F800000, 8'd1);
    check("single_no_start", 32'(start_cnt - s0), 32'd0);

    // Three elements with operand ordering
    issue_a.delete();
    issue_b.delete();
    send_three();
    get_sum("three", 32'h40600000, 8'd3);
    check("three_issues", 32'(issue_a.size()), 32'd2);
    check("three_a0", issue_a[0], 32'h3F800000);
    check("three_b0", issue_b[0], 32'h40000000);
    check("three_a1", issue_a[1], 32'h40400000);
    check("three_b1", issue_b[1], 32'h3F000000);

    // Output backpressure: hold for 5 cycles then handshake
    send_elem(32'h40A00000, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("bp_data", acc_data, 32'h40A00000);
      check("bp_count", 32'(count), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(acc_valid), 32'd1);
      @(negedge clk);
    end
    acc_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_ready = 1'b0;
    check("bp_after_valid", 32'(acc_valid), 32'd0);
    check("bp_after_ready", 32'(in_ready), 32'd1);
    check("bp_after_count", 32'(count), 32'd0);

    // Input gaps of 3 cycles between elements
    s0 = start_cnt;
    send_elem(32'h3F800000, 1'b0);
    repeat (3) @(negedge clk);
    check("gap_no_start", 32'(start_cnt - s0), 32'd0);
    send_elem(32'h40000000, 1'b0);
    repeat (3) @(negedge clk);
    send_elem(32'h3F000000, 1'b1);
    get_sum("gap", 32'h40600000, 8'd3);
    check("gap_starts", 32'(start_cnt - s0), 32'd2);

    // Done on exactly the 64th WAIT cycle is accepted
    lat_m = 63;
    send_elem(32'h3F800000, 1'b0);
    send_elem(32'h40000000, 1'b1);
    get_sum("tmo_edge", 32'h40400000, 8'd2);
    check("tmo_edge_err", 32'(err_timeout), 32'd0);

    // Done one cycle late aborts with the last flag set
    lat_m = 64;
    send_elem(32'h3F800000, 1'b0);
    send_elem(32'h40000000, 1'b1);
    get_sum("tmo_late", 32'h3F800000, 8'd2);
    check("tmo_late_err", 32'(err_timeout), 32'd1);
    lat_m = 3;

    // Hung adder on the second element: drain the rest
    hang_m = 1'b1;
    send_elem(32'h3F800000, 1'b0);
    send_elem(32'h40000000, 1'b0);
    send_elem(32'h40800000, 1'b0);
    send_elem(32'h41000000, 1'b1);
    get_sum("tmo_drain", 32'h3F800000, 8'd4);
    check("tmo_drain_err", 32'(err_timeout), 32'd1);
    hang_m = 1'b0;

    // Error stays sticky while later packets still work
    send_three();
    get_sum("sticky", 32'h40600000, 8'd3);
    check("sticky_err", 32'(err_timeout), 32'd1);

    // Reset in WAIT, then a stale done must not disturb the next packet
    send_elem(32'h3F800000, 1'b0);
    send_elem(32'h40000000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("mid_rst");
    send_three();
    get_sum("post_rst", 32'h40600000, 8'd3);

    check("no_double_start", 32'(dbl_start), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
